// File: rtl/servo_ramp_sequencer_pkg.sv
// Shared types and constants for the servo ramp sequencer: FSM encoding,
// channel geometry and the host register map.
package servo_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int PW_W   = 15;
    localparam int CH_W   = 3;

    localparam logic [7:0] PWM_BASE  = 8'h00;
    localparam logic [7:0] ADDR_TGT  = 8'h20;
    localparam logic [7:0] ADDR_STEP = 8'h30;
    localparam logic [7:0] ADDR_MASK = 8'h38;
    localparam logic [7:0] ADDR_CTRL = 8'h39;
    localparam logic [7:0] ADDR_STAT = 8'h3A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } seq_state_e;

    // Byte address of a channel's pulse-width register in the PWM file.
    function automatic logic [7:0] pwm_byte_addr(input logic [CH_W-1:0] ch, input logic hi);
        return PWM_BASE + {4'b0000, ch, hi};
    endfunction

endpackage

// File: rtl/servo_ramp_sequencer_if.sv
// Host-facing bundle of the sequencer: frame tick, config port and the
// shared PWM register-file write port.
interface servo_ramp_sequencer_if;
    logic       Frame_Tick;
    logic       Cfg_WEn;
    logic [7:0] Cfg_Addr;
    logic [7:0] Cfg_Data;
    logic [7:0] Cfg_RData;
    logic       Host_WEn;
    logic       Pwm_WEn;
    logic [7:0] Pwm_Addr;
    logic [7:0] Pwm_Data;
    logic       Busy;
    logic       Done;

    modport master (
        output Frame_Tick, Cfg_WEn, Cfg_Addr, Cfg_Data, Host_WEn,
        input  Cfg_RData, Pwm_WEn, Pwm_Addr, Pwm_Data, Busy, Done
    );

    modport slave (
        input  Frame_Tick, Cfg_WEn, Cfg_Addr, Cfg_Data, Host_WEn,
        output Cfg_RData, Pwm_WEn, Pwm_Addr, Pwm_Data, Busy, Done
    );
endinterface

// File: rtl/servo_ramp_sequencer_step.sv
// One ramp step toward the target: moves by at most step, lands exactly on
// the target when close enough, and a step of zero jumps straight there.
module servo_ramp_step
    import servo_seq_pkg::*;
(
    input  logic [PW_W-1:0] cur_i,
    input  logic [PW_W-1:0] tgt_i,
    input  logic [7:0]      step_i,
    output logic [PW_W-1:0] next_cur_o
);

    logic            up_s;
    logic [PW_W-1:0] diff_s;
    logic [PW_W-1:0] step_ext_s;

    assign step_ext_s = {{(PW_W-8){1'b0}}, step_i};
    assign up_s       = (tgt_i >= cur_i);
    assign diff_s     = up_s ? (tgt_i - cur_i) : (cur_i - tgt_i);

    // Clamp to the target whenever a full step would reach or pass it.
    always_comb begin
        next_cur_o = tgt_i;
        if ((step_i == 8'd0) || (diff_s <= step_ext_s)) begin
            next_cur_o = tgt_i;
        end else if (up_s) begin
            next_cur_o = cur_i + step_ext_s;
        end else begin
            next_cur_o = cur_i - step_ext_s;
        end
    end

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Frame-synchronous servo ramp sequencer: each frame, steps every enabled
// channel toward its target and writes the result to the PWM register file.
module servo_ramp_sequencer
    import servo_seq_pkg::*;
(
    input  logic                   Clk,
    input  logic                   rst_n,
    servo_ramp_sequencer_if.slave  bus
);

    logic [PW_W-1:0] tgt_q  [NUM_CH];
    logic [PW_W-1:0] cur_q  [NUM_CH];
    logic [7:0]      step_q [NUM_CH];
    logic [7:0]      shadow_q;
    logic [7:0]      mask_q;
    logic            run_q;
    logic            force_q;
    logic            ovr_q;
    logic            all_done_q;

    seq_state_e      state_q;
    logic [CH_W-1:0] ch_q;
    logic            pwm_wen_q;
    logic [7:0]      pwm_addr_q;
    logic [7:0]      pwm_data_q;
    logic            busy_q;
    logic            done_q;

    logic [PW_W-1:0] cur_d;
    logic            last_ch_s;
    logic            need_wr_s;
    logic            all_done_s;
    logic [7:0]      rdata_s;

    servo_ramp_step u_step (
        .cur_i      (cur_q[ch_q]),
        .tgt_i      (tgt_q[ch_q]),
        .step_i     (step_q[ch_q]),
        .next_cur_o (cur_d)
    );

    assign last_ch_s = (ch_q == CH_W'(NUM_CH - 1));
    assign need_wr_s = mask_q[ch_q] && ((cur_q[ch_q] != tgt_q[ch_q]) || force_q);

    // All enabled channels settled; sampled into all_done_q at sweep end.
    always_comb begin
        all_done_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i] && (cur_q[i] != tgt_q[i])) begin
                all_done_s = 1'b0;
            end else begin
                all_done_s = all_done_s;
            end
        end
    end

    // Host configuration registers and the sticky overrun flag.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i]  <= '0;
                step_q[i] <= 8'h00;
            end
            shadow_q <= 8'h00;
            mask_q   <= 8'h00;
            run_q    <= 1'b0;
            force_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (bus.Cfg_WEn) begin
                if (bus.Cfg_Addr[7:4] == ADDR_TGT[7:4]) begin
                    if (bus.Cfg_Addr[0] == 1'b0) begin
                        shadow_q <= bus.Cfg_Data;
                    end else begin
                        tgt_q[bus.Cfg_Addr[3:1]] <= {bus.Cfg_Data[6:0], shadow_q};
                    end
                end else if (bus.Cfg_Addr[7:3] == ADDR_STEP[7:3]) begin
                    step_q[bus.Cfg_Addr[2:0]] <= bus.Cfg_Data;
                end else if (bus.Cfg_Addr == ADDR_MASK) begin
                    mask_q <= bus.Cfg_Data;
                end else if (bus.Cfg_Addr == ADDR_CTRL) begin
                    run_q   <= bus.Cfg_Data[0];
                    force_q <= bus.Cfg_Data[1];
                end
            end
            // A tick that arrives mid-sweep wins over a simultaneous clear.
            if (bus.Frame_Tick && (state_q != IDLE)) begin
                ovr_q <= 1'b1;
            end else if (bus.Cfg_WEn && (bus.Cfg_Addr == ADDR_STAT) && bus.Cfg_Data[2]) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Sweep FSM with registered write port, Busy and Done.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            pwm_wen_q  <= 1'b0;
            pwm_addr_q <= 8'h00;
            pwm_data_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            all_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Frame_Tick && run_q) begin
                        state_q <= CALC;
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    if (need_wr_s) begin
                        cur_q[ch_q] <= cur_d;
                        pwm_addr_q  <= pwm_byte_addr(ch_q, 1'b0);
                        pwm_data_q  <= cur_d[7:0];
                        pwm_wen_q   <= 1'b1;
                        state_q     <= WR_LO;
                    end else if (last_ch_s) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        all_done_q <= all_done_s;
                    end else begin
                        ch_q <= ch_q + 3'd1;
                    end
                end
                WR_LO: begin
                    if (!bus.Host_WEn) begin
                        pwm_addr_q <= pwm_byte_addr(ch_q, 1'b1);
                        pwm_data_q <= {1'b0, cur_q[ch_q][PW_W-1:8]};
                        state_q    <= WR_HI;
                    end
                end
                WR_HI: begin
                    if (!bus.Host_WEn) begin
                        pwm_wen_q <= 1'b0;
                        if (last_ch_s) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            all_done_q <= all_done_s;
                        end else begin
                            ch_q    <= ch_q + 3'd1;
                            state_q <= CALC;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pwm_wen_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency register readback; unmapped addresses read as zero.
    always_comb begin
        rdata_s = 8'h00;
        if (bus.Cfg_Addr[7:4] == ADDR_TGT[7:4]) begin
            if (bus.Cfg_Addr[0]) begin
                rdata_s = {1'b0, tgt_q[bus.Cfg_Addr[3:1]][PW_W-1:8]};
            end else begin
                rdata_s = tgt_q[bus.Cfg_Addr[3:1]][7:0];
            end
        end else if (bus.Cfg_Addr[7:3] == ADDR_STEP[7:3]) begin
            rdata_s = step_q[bus.Cfg_Addr[2:0]];
        end else if (bus.Cfg_Addr == ADDR_MASK) begin
            rdata_s = mask_q;
        end else if (bus.Cfg_Addr == ADDR_CTRL) begin
            rdata_s = {6'b000000, force_q, run_q};
        end else if (bus.Cfg_Addr == ADDR_STAT) begin
            rdata_s = {5'b00000, ovr_q, all_done_q, busy_q};
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign bus.Cfg_RData = rdata_s;
    assign bus.Pwm_WEn   = pwm_wen_q & ~bus.Host_WEn;
    assign bus.Pwm_Addr  = pwm_addr_q;
    assign bus.Pwm_Data  = pwm_data_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Self-checking bench for servo_ramp_sequencer: register-map vector table,
// a reference model feeding a write scoreboard, and hand-built corner cases.
module tb_servo_ramp_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    servo_ramp_sequencer_if bus ();

    servo_ramp_sequencer dut (
        .Clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } pwm_wr_t;

    typedef struct {
        logic       wen;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } cfg_vec_t;

    pwm_wr_t  exp_q[$];
    cfg_vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;

    int       m_cur[8];
    int       m_tgt[8];
    int       m_step[8];
    logic [7:0] m_mask;
    logic     m_force;
    logic     m_ovr;
    logic     m_alldone;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Write-port monitor: pops the scoreboard on every accepted write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Busy) busy_cnt++;
            if (bus.Host_WEn) check("host_yield", int'(bus.Pwm_WEn), 0);
            if (bus.Pwm_WEn && !bus.Host_WEn) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write addr=0x%0h data=0x%0h", bus.Pwm_Addr, bus.Pwm_Data);
                end else begin
                    pwm_wr_t e;
                    e = exp_q.pop_front();
                    check("pwm_write", int'({bus.Pwm_Addr, bus.Pwm_Data}), int'({e.addr, e.data}));
                end
            end
        end
    end

    function automatic int model_next(input int c, input int t, input int s);
        if (s == 0) return t;
        if (t > c) return ((t - c) <= s) ? t : c + s;
        return ((c - t) <= s) ? t : c - s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_step[i] = 0;
        end
        m_mask = 8'h00; m_force = 1'b0; m_ovr = 1'b0; m_alldone = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_sweep(output int len);
        pwm_wr_t w;
        int nc;
        len = 0;
        m_alldone = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            if (m_mask[ch] && ((m_cur[ch] != m_tgt[ch]) || m_force)) begin
                nc = model_next(m_cur[ch], m_tgt[ch], m_step[ch]);
                m_cur[ch] = nc;
                w.addr = 8'(2 * ch);      w.data = 8'(nc & 255);         exp_q.push_back(w);
                w.addr = 8'(2 * ch + 1);  w.data = 8'((nc >> 8) & 127);  exp_q.push_back(w);
                len += 3;
            end else begin
                len += 1;
            end
            if (m_mask[ch] && (m_cur[ch] != m_tgt[ch])) m_alldone = 1'b0;
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        bus.Cfg_WEn = 1'b1; bus.Cfg_Addr = a; bus.Cfg_Data = d;
        @(posedge clk); #1;
        bus.Cfg_WEn = 1'b0;
    endtask

    task automatic cfg_read(input string name, input logic [7:0] a, input logic [7:0] exp);
        bus.Cfg_Addr = a;
        #1;
        check(name, int'(bus.Cfg_RData), int'(exp));
    endtask

    task automatic set_tgt(input int ch, input int v);
        cfg_write(8'(8'h20 + 2 * ch), 8'(v & 255));
        cfg_write(8'(8'h21 + 2 * ch), 8'((v >> 8) & 127));
        m_tgt[ch] = v;
    endtask

    task automatic set_step(input int ch, input int v);
        cfg_write(8'(8'h30 + ch), 8'(v));
        m_step[ch] = v;
    endtask

    task automatic set_mask(input logic [7:0] m);
        cfg_write(8'h38, m);
        m_mask = m;
    endtask

    task automatic set_ctrl(input logic run, input logic frc);
        cfg_write(8'h39, {6'b000000, frc, run});
        m_force = frc;
    endtask

    task automatic tick();
        bus.Frame_Tick = 1'b1;
        @(posedge clk); #1;
        bus.Frame_Tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Host_WEn = 1'b0; bus.Frame_Tick = 1'b0; bus.Cfg_WEn = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_done(input int exp_len);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("sweep_len", busy_cnt, exp_len);
            check("queue_drained", exp_q.size(), 0);
            @(negedge clk);
            check("done_pulse", int'({bus.Done, bus.Busy}), 0);
        end
    endtask

    task automatic run_sweep();
        int len;
        model_sweep(len);
        busy_cnt = 0;
        tick();
        wait_done(len);
    endtask

    function automatic logic [7:0] exp_stat();
        return {5'b00000, m_ovr, m_alldone, 1'b0};
    endfunction

    initial begin
        int len;
        rst_n = 1'b0;
        bus.Frame_Tick = 1'b0; bus.Cfg_WEn = 1'b0; bus.Cfg_Addr = 8'h00;
        bus.Cfg_Data = 8'h00; bus.Host_WEn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", int'({bus.Pwm_WEn, bus.Busy, bus.Done}), 0);
        check("rst_addr_data", int'({bus.Pwm_Addr, bus.Pwm_Data}), 0);
        rst_n = 1'b1;

        vecs[0] = '{1'b1, 8'h20, 8'h34, 8'h00};
        vecs[1] = '{1'b1, 8'h21, 8'h85, 8'h05};
        vecs[2] = '{1'b0, 8'h20, 8'h00, 8'h34};
        vecs[3] = '{1'b1, 8'h31, 8'h0A, 8'h0A};
        vecs[4] = '{1'b1, 8'h38, 8'hA5, 8'hA5};
        vecs[5] = '{1'b1, 8'h39, 8'hFF, 8'h03};
        vecs[6] = '{1'b1, 8'h39, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 8'h3B, 8'h00, 8'h00};
        vecs[8] = '{1'b1, 8'h3A, 8'hFF, 8'h00};
        vecs[9] = '{1'b0, 8'h40, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wen) cfg_write(vecs[i].addr, vecs[i].data);
            cfg_read($sformatf("regmap_%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Ramp up from 0 to 1500 in steps of 100, first write latency checked.
        do_reset();
        set_tgt(0, 1500); set_step(0, 100); set_mask(8'h01); set_ctrl(1'b1, 1'b0);
        model_sweep(len);
        busy_cnt = 0;
        tick();
        @(negedge clk);
        check("lat_calc", int'({bus.Busy, bus.Pwm_WEn}), 2);
        @(negedge clk);
        check("lat_first_wr", int'({bus.Pwm_WEn, bus.Pwm_Addr, bus.Pwm_Data}), int'({1'b1, 8'h00, 8'h64}));
        wait_done(len);
        cfg_read("ramp_stat_1", 8'h3A, exp_stat());
        for (int t = 1; t < 15; t++) run_sweep();
        check("ramp_model_end", m_cur[0], 1500);
        cfg_read("ramp_alldone", 8'h3A, 8'h02);

        // Clamp: 1450 -> 1500 with step 100 must not overshoot.
        do_reset();
        set_tgt(0, 1450); set_step(0, 0); set_mask(8'h01); set_ctrl(1'b1, 1'b0);
        run_sweep();
        set_tgt(0, 1500); set_step(0, 100);
        run_sweep();
        check("clamp_value", m_cur[0], 1500);
        run_sweep();
        cfg_read("clamp_stat", 8'h3A, 8'h02);

        // Arbitration: host holds the port for 3 cycles during WR_LO.
        set_tgt(0, 1600);
        model_sweep(len);
        busy_cnt = 0;
        tick();
        @(posedge clk); #1;
        bus.Host_WEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wen", int'(bus.Pwm_WEn), 0);
            @(posedge clk); #1;
        end
        bus.Host_WEn = 1'b0;
        wait_done(len + 3);

        // Skip/order: only channels 5 and 7 enabled; channel 6 differs but masked.
        do_reset();
        set_tgt(5, 300); set_tgt(6, 50); set_tgt(7, 700);
        set_mask(8'hA0); set_ctrl(1'b1, 1'b0);
        run_sweep();

        // Overrun: a second tick mid-sweep is flagged and dropped.
        set_tgt(5, 400);
        model_sweep(len);
        busy_cnt = 0;
        tick();
        @(posedge clk); #1;
        tick();
        m_ovr = 1'b1;
        wait_done(len);
        repeat (20) @(negedge clk);
        check("ovr_no_extra_sweep", busy_cnt, len);
        cfg_read("ovr_stat", 8'h3A, exp_stat());
        cfg_write(8'h3A, 8'h04);
        m_ovr = 1'b0;
        cfg_read("ovr_cleared", 8'h3A, exp_stat());

        // Reset asserted during WR_HI abandons the sweep immediately.
        set_tgt(5, 500);
        model_sweep(len);
        tick();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.Pwm_WEn && (bus.Pwm_Addr == 8'h0B)) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rst_reach_wr_hi", int'(seen), 1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_wen", int'(bus.Pwm_WEn), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        cfg_read("rst_stat", 8'h3A, 8'h00);
        cfg_read("rst_ctrl", 8'h39, 8'h00);
        cfg_read("rst_tgt5_hi", 8'h2B, 8'h00);
        busy_cnt = 0;
        tick();
        repeat (20) @(negedge clk);
        check("rst_no_run", busy_cnt, 0);
        set_tgt(0, 10); set_mask(8'h01); set_ctrl(1'b1, 1'b0);
        run_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
